// File: rtl/chip_all_pkg.sv
// Shared widths, reset constants and sequencer state encoding for the RGB-D VO control shell.
package chip_all_pkg;

    localparam int unsigned POSE_BW     = 42;
    localparam int unsigned CLOUD_BW    = 42;
    localparam int unsigned DATA_RGB_BW = 8;
    localparam int unsigned POSE_N      = 12;

    localparam logic [POSE_BW-1:0]       POSE_ONE       = 42'd16777216;
    localparam logic [2*CLOUD_BW-1:0]    SIGMA_ICP_RST  = 84'd7774054188783816;
    localparam logic [DATA_RGB_BW:0]     SIGMA_RGBD_RST = 9'd5;

    typedef logic [POSE_N-1:0][POSE_BW-1:0] pose_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_F_INGEST,
        ST_F_SOLVE,
        ST_D_INGEST,
        ST_D_SOLVE
    } state_e;

    // 3x4 row-major [R|t] with unit diagonal
    function automatic pose_t identity_pose();
        pose_t p;
        p     = '0;
        p[0]  = POSE_ONE;
        p[5]  = POSE_ONE;
        p[10] = POSE_ONE;
        return p;
    endfunction

endpackage

// File: rtl/frame_counter.sv
// Valid-beat counter for one pixel stream: clears on frame start, saturates at N, flags completion.
module frame_counter #(
    parameter int unsigned CNT_BW = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [CNT_BW-1:0] i_n,
    output logic              o_done
);

    logic [CNT_BW-1:0] count_q, count_d;
    logic              last_beat;

    // The start beat itself counts when it carries valid data
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = (i_valid && (i_n != '0)) ? CNT_BW'(1) : '0;
        end else if (i_en && i_valid && (count_q < i_n)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Look ahead on the final beat so the registered pulse lands one cycle later
    assign last_beat = i_en && i_valid && (({1'b0, count_q} + 1'b1) == {1'b0, i_n});
    assign o_done    = (count_q >= i_n) || last_beat;

endmodule

// File: rtl/chip_all_seq.sv
// Sequencer/control shell: frames pixel streams, runs feature and direct phases, hands frames to the pose engine.
// Optional frame-end completion is enabled by defining CHIP_ALL_FRAME_END_EN.
module chip_all_seq
    import chip_all_pkg::*;
#(
    parameter int unsigned DEPTH_BW = 16,
    parameter int unsigned INTR_BW  = 35,
    parameter int unsigned SIZE_BW  = 10
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_frame_start,
    input  logic                        i_frame_end,
    input  logic                        i_f_or_d,
    input  logic [3:0]                  i_n_of_f,
    input  logic                        i_valid_0,
    input  logic [DATA_RGB_BW-1:0]      i_data0,
    input  logic [DEPTH_BW-1:0]         i_depth0,
    input  logic                        i_valid_1,
    input  logic [DATA_RGB_BW-1:0]      i_data1,
    input  logic [DEPTH_BW-1:0]         i_depth1,
    input  pose_t                       i_pose,
    input  logic [INTR_BW-1:0]          r_fx,
    input  logic [INTR_BW-1:0]          r_fy,
    input  logic [INTR_BW-1:0]          r_cx,
    input  logic [INTR_BW-1:0]          r_cy,
    input  logic [SIZE_BW-1:0]          r_hsize,
    input  logic [SIZE_BW-1:0]          r_vsize,
    input  logic [2*CLOUD_BW-1:0]       sigma_icp,
    input  logic [DATA_RGB_BW:0]        sigma_rgbd,
    output logic                        o_feature_ready,
    output logic                        o_done,
    output pose_t                       o_pose,
    output logic [2*CLOUD_BW-1:0]       o_sigma_icp,
    output logic [DATA_RGB_BW:0]        o_sigma_rgbd,
    output logic                        o_update_done,
    output logic                        o_eng_start,
    output logic                        o_eng_mode,
    output logic [DATA_RGB_BW+DEPTH_BW:0] o_eng_px0,
    output logic [DATA_RGB_BW+DEPTH_BW:0] o_eng_px1,
    output logic [4*INTR_BW-1:0]        o_eng_cam,
    output logic [2*CLOUD_BW+DATA_RGB_BW:0] o_eng_sigma,
    output pose_t                       o_eng_pose_init,
    input  logic                        i_eng_done,
    input  pose_t                       i_eng_pose,
    input  logic [2*CLOUD_BW-1:0]       i_eng_sigma_icp,
    input  logic [DATA_RGB_BW:0]        i_eng_sigma_rgbd
);

    localparam int unsigned CNT_BW = 2 * SIZE_BW;
    localparam int unsigned PX_BW  = 1 + DATA_RGB_BW + DEPTH_BW;
    localparam int unsigned ESG_BW = 2 * CLOUD_BW + DATA_RGB_BW + 1;

    state_e                  state_q, state_d;
    logic [3:0]              fcnt_q, fcnt_d, ucnt_q, ucnt_d, fcnt_inc, ucnt_inc;
    pose_t                   pose_q, pose_d, pinit_q, pinit_d;
    logic [2*CLOUD_BW-1:0]   sicp_q, sicp_d;
    logic [DATA_RGB_BW:0]    srgbd_q, srgbd_d;
    logic [4*INTR_BW-1:0]    cam_q, cam_d;
    logic [ESG_BW-1:0]       esig_q, esig_d;
    logic                    mode_q, mode_d;
    logic                    ready_q, ready_d, done_q, done_d, upd_q, upd_d, start_q, start_d;
    logic [PX_BW-1:0]        px0_q, px1_q;
    logic [CNT_BW-1:0]       frame_n;
    logic                    start_ok, done0, done1, fend, f_done, d_done;

    assign frame_n  = CNT_BW'(r_hsize) * CNT_BW'(r_vsize);
    assign start_ok = (state_q == ST_IDLE) && i_frame_start;

    frame_counter #(.CNT_BW(CNT_BW)) u_cnt0 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (start_ok),
        .i_en    ((state_q == ST_F_INGEST) || (state_q == ST_D_INGEST)),
        .i_valid (i_valid_0),
        .i_n     (frame_n),
        .o_done  (done0)
    );

    frame_counter #(.CNT_BW(CNT_BW)) u_cnt1 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (start_ok),
        .i_en    (state_q == ST_D_INGEST),
        .i_valid (i_valid_1),
        .i_n     (frame_n),
        .o_done  (done1)
    );

`ifdef CHIP_ALL_FRAME_END_EN
    assign fend = i_frame_end;
`else
    logic unused_frame_end;
    assign unused_frame_end = i_frame_end;
    assign fend             = 1'b0;
`endif

    assign f_done = fend || done0;
    assign d_done = fend || (done0 && done1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (i_frame_start) state_d = i_f_or_d ? ST_D_INGEST : ST_F_INGEST;
            ST_F_INGEST: if (f_done) state_d = (fcnt_q == '0) ? ST_IDLE : ST_F_SOLVE;
            ST_F_SOLVE:  if (i_eng_done) state_d = ST_IDLE;
            ST_D_INGEST: if (d_done) state_d = ST_D_SOLVE;
            ST_D_SOLVE:  if (i_eng_done) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fcnt_d   = fcnt_q;
        ucnt_d   = ucnt_q;
        pose_d   = pose_q;
        pinit_d  = pinit_q;
        sicp_d   = sicp_q;
        srgbd_d  = srgbd_q;
        cam_d    = cam_q;
        esig_d   = esig_q;
        mode_d   = mode_q;
        ready_d  = 1'b0;
        done_d   = 1'b0;
        upd_d    = 1'b0;
        start_d  = 1'b0;
        fcnt_inc = (fcnt_q == 4'hF) ? fcnt_q : fcnt_q + 4'd1;
        ucnt_inc = (ucnt_q == 4'hF) ? ucnt_q : ucnt_q + 4'd1;
        case (state_q)
            ST_IDLE: begin
                if (i_frame_start) begin
                    cam_d  = {r_fx, r_fy, r_cx, r_cy};
                    esig_d = {sigma_icp, sigma_rgbd};
                    mode_d = i_f_or_d;
                    if (i_f_or_d) pinit_d = i_pose;
                end
            end
            ST_F_INGEST: begin
                if (f_done) begin
                    fcnt_d = fcnt_inc;
                    if (fcnt_q == '0) begin
                        done_d  = (i_n_of_f <= 4'd1);
                        ready_d = (i_n_of_f > 4'd1);
                    end else begin
                        pinit_d = pose_q;
                        start_d = 1'b1;
                    end
                end
            end
            ST_F_SOLVE: begin
                if (i_eng_done) begin
                    pose_d  = i_eng_pose;
                    upd_d   = 1'b1;
                    ucnt_d  = ucnt_inc;
                    // 5-bit compare keeps i_n_of_f=0 from aliasing to 15
                    done_d  = ({1'b0, ucnt_inc} == ({1'b0, i_n_of_f} - 5'd1));
                    ready_d = !done_d;
                end
            end
            ST_D_INGEST: begin
                if (d_done) start_d = 1'b1;
            end
            ST_D_SOLVE: begin
                if (i_eng_done) begin
                    pose_d  = i_eng_pose;
                    sicp_d  = i_eng_sigma_icp;
                    srgbd_d = i_eng_sigma_rgbd;
                    upd_d   = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fcnt_q  <= '0;
            ucnt_q  <= '0;
            pose_q  <= identity_pose();
            pinit_q <= '0;
            sicp_q  <= SIGMA_ICP_RST;
            srgbd_q <= SIGMA_RGBD_RST;
            cam_q   <= '0;
            esig_q  <= '0;
            mode_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            upd_q   <= 1'b0;
            start_q <= 1'b0;
            px0_q   <= '0;
            px1_q   <= '0;
        end else begin
            fcnt_q  <= fcnt_d;
            ucnt_q  <= ucnt_d;
            pose_q  <= pose_d;
            pinit_q <= pinit_d;
            sicp_q  <= sicp_d;
            srgbd_q <= srgbd_d;
            cam_q   <= cam_d;
            esig_q  <= esig_d;
            mode_q  <= mode_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            upd_q   <= upd_d;
            start_q <= start_d;
            px0_q   <= {i_valid_0, i_data0, i_depth0};
            px1_q   <= {i_valid_1, i_data1, i_depth1};
        end
    end

    assign o_feature_ready = ready_q;
    assign o_done          = done_q;
    assign o_update_done   = upd_q;
    assign o_eng_start     = start_q;
    assign o_pose          = pose_q;
    assign o_sigma_icp     = sicp_q;
    assign o_sigma_rgbd    = srgbd_q;
    assign o_eng_mode      = mode_q;
    assign o_eng_px0       = px0_q;
    assign o_eng_px1       = px1_q;
    assign o_eng_cam       = cam_q;
    assign o_eng_sigma     = esig_q;
    assign o_eng_pose_init = pinit_q;

endmodule

// File: tb/tb_chip_all_seq.sv
// Directed bench for chip_all_seq: feature phase, direct phase, boundary cases and reset abort.
module tb_chip_all_seq;
    import chip_all_pkg::*;

`ifdef CHIP_ALL_FRAME_END_EN
    localparam bit FE_ON = 1'b1;
`else
    localparam bit FE_ON = 1'b0;
`endif

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic          i_rst, i_frame_start, i_frame_end, i_f_or_d;
    logic [3:0]    i_n_of_f;
    logic          i_valid_0, i_valid_1;
    logic [7:0]    i_data0, i_data1;
    logic [15:0]   i_depth0, i_depth1;
    pose_t         i_pose, o_pose, o_eng_pose_init, i_eng_pose;
    logic [34:0]   r_fx, r_fy, r_cx, r_cy;
    logic [9:0]    r_hsize, r_vsize;
    logic [83:0]   sigma_icp, o_sigma_icp, i_eng_sigma_icp;
    logic [8:0]    sigma_rgbd, o_sigma_rgbd, i_eng_sigma_rgbd;
    logic          o_feature_ready, o_done, o_update_done, o_eng_start, o_eng_mode, i_eng_done;
    logic [24:0]   o_eng_px0, o_eng_px1;
    logic [139:0]  o_eng_cam;
    logic [92:0]   o_eng_sigma;

    chip_all_seq dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_frame_start(i_frame_start), .i_frame_end(i_frame_end),
        .i_f_or_d(i_f_or_d), .i_n_of_f(i_n_of_f),
        .i_valid_0(i_valid_0), .i_data0(i_data0), .i_depth0(i_depth0),
        .i_valid_1(i_valid_1), .i_data1(i_data1), .i_depth1(i_depth1),
        .i_pose(i_pose), .r_fx(r_fx), .r_fy(r_fy), .r_cx(r_cx), .r_cy(r_cy),
        .r_hsize(r_hsize), .r_vsize(r_vsize), .sigma_icp(sigma_icp), .sigma_rgbd(sigma_rgbd),
        .o_feature_ready(o_feature_ready), .o_done(o_done), .o_pose(o_pose),
        .o_sigma_icp(o_sigma_icp), .o_sigma_rgbd(o_sigma_rgbd), .o_update_done(o_update_done),
        .o_eng_start(o_eng_start), .o_eng_mode(o_eng_mode), .o_eng_px0(o_eng_px0),
        .o_eng_px1(o_eng_px1), .o_eng_cam(o_eng_cam), .o_eng_sigma(o_eng_sigma),
        .o_eng_pose_init(o_eng_pose_init), .i_eng_done(i_eng_done), .i_eng_pose(i_eng_pose),
        .i_eng_sigma_icp(i_eng_sigma_icp), .i_eng_sigma_rgbd(i_eng_sigma_rgbd)
    );

    int unsigned n_checks = 0, n_fail = 0;
    int unsigned sp_ready = 0, sp_done = 0, sp_upd = 0, sp_start = 0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        if (o_feature_ready) sp_ready++;
        if (o_done)          sp_done++;
        if (o_update_done)   sp_upd++;
        if (o_eng_start)     sp_start++;
    endtask

    task automatic beats(input int unsigned n, input logic v0, input logic v1);
        for (int unsigned k = 0; k < n; k++) begin
            i_valid_0 = v0;
            i_valid_1 = v1;
            i_data0   = 8'(k + 1);
            i_depth0  = 16'((k + 1) * 100);
            i_data1   = 8'(k + 2);
            i_depth1  = 16'(k * 7);
            tick();
        end
        i_valid_0 = 1'b0;
        i_valid_1 = 1'b0;
    endtask

    task automatic start_frame(input logic dir);
        i_f_or_d      = dir;
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
    endtask

    task automatic eng_finish();
        i_eng_done = 1'b1;
        tick();
        i_eng_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst = 1'b1; i_frame_start = 1'b0; i_frame_end = 1'b0; i_f_or_d = 1'b0;
        i_n_of_f = 4'd3; i_valid_0 = 1'b0; i_valid_1 = 1'b0;
        i_data0 = '0; i_data1 = '0; i_depth0 = '0; i_depth1 = '0;
        i_pose = '0; i_eng_pose = identity_pose(); i_eng_done = 1'b0;
        r_fx = 35'd11; r_fy = 35'd22; r_cx = 35'd33; r_cy = 35'd44;
        r_hsize = 10'd4; r_vsize = 10'd2;
        sigma_icp = 84'd1000; sigma_rgbd = 9'd3;
        i_eng_sigma_icp = '0; i_eng_sigma_rgbd = '0;

        tick(); tick();
        check("rst_pose0", 160'(o_pose[0]), 160'd16777216);
        check("rst_pose1", 160'(o_pose[1]), 160'd0);
        check("rst_pose10", 160'(o_pose[10]), 160'd16777216);
        check("rst_sig_rgbd", 160'(o_sigma_rgbd), 160'd5);
        check("rst_sig_icp", 160'(o_sigma_icp), 160'd7774054188783816);
        check("rst_pulses", 160'({o_feature_ready, o_done, o_update_done, o_eng_start}), 160'd0);
        check("rst_px0", 160'(o_eng_px0), 160'd0);
        i_rst = 1'b0;
        tick();
        sp_ready = 0; sp_done = 0; sp_upd = 0; sp_start = 0;

        // Frame 1: first feature frame only signals readiness
        start_frame(1'b0);
        r_fx = 35'd99;
        beats(4, 1'b1, 1'b0);
        i_valid_0 = 1'b1; i_data0 = 8'hA5; i_depth0 = 16'h1234;
        i_valid_1 = 1'b0; i_data1 = 8'h3C; i_depth1 = 16'h0BEE;
        tick();
        i_valid_0 = 1'b0;
        check("px0_reg", 160'(o_eng_px0), 160'({1'b1, 8'hA5, 16'h1234}));
        check("px1_reg", 160'(o_eng_px1), 160'({1'b0, 8'h3C, 16'h0BEE}));
        check("f1_early", 160'(sp_ready), 160'd0);
        beats(3, 1'b1, 1'b0);
        check("f1_ready", 160'(o_feature_ready), 160'd1);
        check("f1_no_start", 160'(o_eng_start), 160'd0);
        check("f1_no_done", 160'(o_done), 160'd0);
        check("cam_latched", 160'(o_eng_cam), 160'({35'd11, 35'd22, 35'd33, 35'd44}));
        check("esig_latched", 160'(o_eng_sigma), 160'({84'd1000, 9'd3}));
        tick();
        check("f1_ready_width", 160'(o_feature_ready), 160'd0);

        // Frame 2: engine solve; stray start and beats in F_SOLVE must be ignored
        start_frame(1'b0);
        beats(8, 1'b1, 1'b0);
        check("f2_start", 160'(o_eng_start), 160'd1);
        check("f2_pinit0", 160'(o_eng_pose_init[0]), 160'd16777216);
        check("f2_mode", 160'(o_eng_mode), 160'd0);
        start_frame(1'b1);
        beats(3, 1'b1, 1'b1);
        i_eng_pose[3] = 42'd100;
        eng_finish();
        check("f2_upd", 160'(o_update_done), 160'd1);
        check("f2_ready", 160'(o_feature_ready), 160'd1);
        check("f2_done", 160'(o_done), 160'd0);
        check("f2_pose3", 160'(o_pose[3]), 160'd100);

        // Engine done while idle is ignored
        i_eng_pose[3] = 42'd999;
        eng_finish();
        check("idle_eng_upd", 160'(o_update_done), 160'd0);
        check("idle_eng_pose", 160'(o_pose[3]), 160'd100);

        // Frame 3: last update closes the feature phase
        start_frame(1'b0);
        beats(8, 1'b1, 1'b0);
        check("f3_start", 160'(o_eng_start), 160'd1);
        i_eng_pose[3] = 42'd200;
        eng_finish();
        check("f3_upd", 160'(o_update_done), 160'd1);
        check("f3_done", 160'(o_done), 160'd1);
        check("f3_ready", 160'(o_feature_ready), 160'd0);
        check("f3_pose3", 160'(o_pose[3]), 160'd200);
        check("n_upd", 160'(sp_upd), 160'd2);
        check("n_ready", 160'(sp_ready), 160'd2);
        check("n_done", 160'(sp_done), 160'd1);

        // Direct iteration: engine starts only once both streams are full
        i_pose = '0;
        i_pose[11] = 42'd7;
        start_frame(1'b1);
        i_f_or_d = 1'b0;
        i_pose = '0;
        beats(8, 1'b0, 1'b1);
        beats(3, 1'b0, 1'b1);
        check("d_wait_both", 160'(sp_start), 160'd2);
        beats(7, 1'b1, 1'b0);
        check("d_wait_last", 160'(o_eng_start), 160'd0);
        beats(1, 1'b1, 1'b0);
        check("d_start", 160'(o_eng_start), 160'd1);
        check("d_pinit11", 160'(o_eng_pose_init[11]), 160'd7);
        check("d_mode", 160'(o_eng_mode), 160'd1);
        i_eng_pose = identity_pose();
        i_eng_pose[11] = 42'd55;
        i_eng_sigma_rgbd = 9'd9;
        i_eng_sigma_icp = 84'd12345;
        eng_finish();
        check("d_done_upd", 160'({o_done, o_update_done}), 160'd3);
        check("d_sig_rgbd", 160'(o_sigma_rgbd), 160'd9);
        check("d_sig_icp", 160'(o_sigma_icp), 160'd12345);
        check("d_pose11", 160'(o_pose[11]), 160'd55);

        // N=0: frame completes on the first ingest cycle
        r_hsize = 10'd0;
        start_frame(1'b0);
        tick();
        check("n0_start", 160'(o_eng_start), 160'd1);
        eng_finish();
        check("n0_upd", 160'(o_update_done), 160'd1);
        check("n0_ready", 160'(o_feature_ready), 160'd1);
        r_hsize = 10'd4;

        // Reset mid direct ingest aborts to the reset state
        start_frame(1'b1);
        beats(3, 1'b1, 1'b1);
        i_rst = 1'b1;
        tick();
        check("abort_pose0", 160'(o_pose[0]), 160'd16777216);
        check("abort_pose11", 160'(o_pose[11]), 160'd0);
        check("abort_sig_rgbd", 160'(o_sigma_rgbd), 160'd5);
        i_rst = 1'b0;
        tick();

        // Single-frame feature phase; the valid start beat counts toward N
        i_n_of_f = 4'd1;
        i_valid_0 = 1'b1;
        start_frame(1'b0);
        beats(6, 1'b1, 1'b0);
        check("nf1_early", 160'(o_done), 160'd0);
        beats(1, 1'b1, 1'b0);
        check("nf1_done", 160'(o_done), 160'd1);
        check("nf1_ready", 160'(o_feature_ready), 160'd0);

        // Frame-end completion (only when the feature is built in)
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_n_of_f = 4'd3;
        tick();
        start_frame(1'b0);
        beats(5, 1'b1, 1'b0);
        i_frame_end = 1'b1;
        tick();
        i_frame_end = 1'b0;
        check("fend_ready", 160'(o_feature_ready), 160'(FE_ON));
        beats(3, 1'b1, 1'b0);
        check("fend_count_ready", 160'(o_feature_ready), 160'(!FE_ON));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chip_all_seq.md
Name: chip_all_seq

Overview:
- Top-level sequencer and control shell of the RGB-D visual-odometry chip.
- Frames the pixel/depth streams, counts frames, and runs two phases: feature phase (i_f_or_d=0), then direct phase (i_f_or_d=1).
- Hands each completed frame set to an external pose engine. Holds the pose and sigma registers and emits the done/ready/update pulses.

Parameters:
- POSE_BW, 42, pose element width, signed Q24 (1.0 = 16777216).
- CLOUD_BW, 42, sigma_icp is 2*CLOUD_BW = 84 bits.
- DATA_RGB_BW, 8, pixel width; sigma_rgbd is DATA_RGB_BW+1 = 9 bits.
- DEPTH_BW, 16, depth width.
- INTR_BW, 35, camera intrinsic width.
- SIZE_BW, 10, hsize/vsize width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_frame_start  in  1  frame start pulse.
- i_frame_end  in  1  frame end pulse; used only with the optional feature.
- i_f_or_d  in  1  phase select: 0 = feature, 1 = direct.
- i_n_of_f  in  4  number of feature frames.
- i_valid_0 / i_data0 / i_depth0  in  1/8/16  reference stream.
- i_valid_1 / i_data1 / i_depth1  in  1/8/16  current stream (direct phase).
- i_pose  in  12x42  initial pose for the direct phase.
- r_fx, r_fy, r_cx, r_cy  in  35 each  camera intrinsics.
- r_hsize, r_vsize  in  10 each  image size.
- sigma_icp  in  84  current ICP sigma.
- sigma_rgbd  in  9  current RGBD sigma.
- o_feature_ready  out  1  pulse: ready for the next feature frame.
- o_done  out  1  pulse: phase or iteration complete.
- o_pose  out  12x42  current pose.
- o_sigma_icp  out  84  next ICP sigma.
- o_sigma_rgbd  out  9  next RGBD sigma.
- o_update_done  out  1  pulse: pose updated.
- o_eng_start  out  1  engine start pulse.
- o_eng_mode  out  1  engine mode; copy of the phase.
- o_eng_px0, o_eng_px1  out  25 each  {valid,data,depth}, inputs registered one cycle.
- o_eng_cam  out  140  {fx,fy,cx,cy}, latched at frame start.
- o_eng_sigma  out  93  {sigma_icp,sigma_rgbd}, latched at frame start.
- o_eng_pose_init  out  12x42  initial pose for the engine.
- i_eng_done  in  1  engine done pulse.
- i_eng_pose  in  12x42  engine result pose.
- i_eng_sigma_icp  in  84  engine result ICP sigma.
- i_eng_sigma_rgbd  in  9  engine result RGBD sigma.

Behaviour:
- Reset:
  - State IDLE; all counters 0; all pulses 0; o_eng_px* 0.
  - o_pose = identity: elements 0, 5, 10 = 16777216, all others 0.
  - o_sigma_icp = 84'd7774054188783816; o_sigma_rgbd = 5.
- States: IDLE, F_INGEST, F_SOLVE, D_INGEST, D_SOLVE.
- Frame size: N = r_hsize*r_vsize (20-bit product). Pixel counters are 20 bits and saturate at N.
- IDLE:
  - On i_frame_start, latch intrinsics and sigmas, clear the pixel counters.
  - i_f_or_d=0: go to F_INGEST.
  - i_f_or_d=1: load o_eng_pose_init from i_pose, go to D_INGEST.
- F_INGEST:
  - Count cycles with i_valid_0=1. The frame is complete when the count reaches N.
  - Frame count fcnt==0: pulse o_feature_ready, increment fcnt, go to IDLE. If i_n_of_f<=1, pulse o_done instead of o_feature_ready.
  - Otherwise: set o_eng_pose_init=o_pose, pulse o_eng_start (1 cycle), increment fcnt, go to F_SOLVE.
- F_SOLVE:
  - On i_eng_done: o_pose<=i_eng_pose, pulse o_update_done, increment update count ucnt.
  - If ucnt reaches i_n_of_f-1: pulse o_done in the same cycle; else pulse o_feature_ready.
  - Go to IDLE.
- D_INGEST:
  - Count i_valid_1 and i_valid_0 independently.
  - When both counts reach N: pulse o_eng_start, go to D_SOLVE.
- D_SOLVE:
  - On i_eng_done: o_pose<=i_eng_pose, o_sigma_*<=i_eng_sigma_*.
  - Pulse o_update_done and o_done in the same cycle; go to IDLE.
- Output timing: all pulses are registered, 1 cycle wide, and occur 1 cycle after the triggering condition.
- Boundary rules:
  - i_frame_start outside IDLE is ignored.
  - Valid beats after a count reaches N are ignored.
  - i_eng_done outside the SOLVE states is ignored.
  - N=0: the frame is complete on the first INGEST cycle.
  - A start beat that is also valid is counted.
  - i_f_or_d is sampled only in IDLE.
  - Reset mid-operation aborts to the reset state.
  - fcnt and ucnt saturate at 15.

Optional Feature:
- Macro: CHIP_ALL_FRAME_END_EN.
- Defined: a frame (in direct phase, both streams) completes on i_frame_end during INGEST, or on count==N, whichever comes first.
- Undefined: i_frame_end is ignored and completion is by count only.

Decomposition:
- Package chip_all_pkg: POSE_BW, CLOUD_BW, DATA_RGB_BW, the identity-pose constant, the reset sigma constants, and the state enum.
- Sub-module frame_counter: valid-beat counter with clear, saturation at N, and a done flag. Instantiated twice (streams 0 and 1).

Test Plan:
- Reset check: after reset, o_pose[0]=16777216, o_pose[1]=0; o_sigma_rgbd=5; all pulses 0.
- First feature frame: hsize=4, vsize=2, i_n_of_f=3, start plus 8 valid_0 beats -> o_feature_ready pulses once, o_eng_start stays 0.
- Feature updates: two more frames, each with i_eng_done and i_eng_pose[3]=100 then 200 -> two o_update_done pulses; o_done on the second; o_pose[3]=200.
- Direct iteration: i_f_or_d=1, i_pose[11]=7; 8 valid_1 beats then 8 delayed valid_0 beats -> o_eng_start only after both, o_eng_pose_init[11]=7. Then i_eng_done with i_eng_sigma_rgbd=9 -> o_done and o_update_done in the same cycle, o_sigma_rgbd=9.
- Robustness: i_frame_start during F_SOLVE is ignored; 3 extra valid beats after N do not change counts; reset mid D_INGEST returns to identity pose.
- With CHIP_ALL_FRAME_END_EN: i_frame_end after 5 beats -> frame completes at 5 beats.
